// File: rtl/asteroid_controller_pkg.sv
// rtl/asteroid_controller_pkg.sv - shared game geometry, position widths and controller state encoding
package asteroid_controller_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int AST_SIZE = 10;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_FALL,
        ST_COOLDOWN,
        ST_MISS
    } state_t;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, reset to a nonzero seed
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    output logic [7:0] value
);

    always_ff @(posedge clock) begin
        if (reset) begin
            value <= SEED;
        end else if (enable) begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/asteroid_controller.sv
// rtl/asteroid_controller.sv - spawns, drops and retires the single asteroid; drives position, redraw and miss pulses
module asteroid_controller
    import asteroid_controller_pkg::*;
#(
    parameter int         TICK_DIV       = 833333,
    parameter int         COOLDOWN_TICKS = 30,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           destroy,
    output logic [X_W-1:0] asteroidx,
    output logic [Y_W-1:0] asteroidy,
    output logic           active,
    output logic           moved,
    output logic           miss,
    output logic [1:0]     level
);

    localparam int XMAX = SCREEN_W - AST_SIZE;
    localparam int YMAX = SCREEN_H - AST_SIZE;
    localparam int TW   = $clog2(TICK_DIV + 1);
    localparam int CW   = $clog2(COOLDOWN_TICKS + 1);

    state_t         state, state_d;
    logic [TW-1:0]  tick_cnt, tick_d;
    logic [CW-1:0]  cool_cnt, cool_d;
    logic [2:0]     kill_cnt, kill_d;
    logic [1:0]     level_d;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    logic           active_d, moved_d, miss_d;
    logic [7:0]     lfsr;
    logic [7:0]     ny;
    logic           tick_done, cool_done;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .value  (lfsr)
    );

    assign tick_done = (tick_cnt == TW'(TICK_DIV - 1));
    assign cool_done = tick_done && (cool_cnt == CW'(COOLDOWN_TICKS - 1));
    // 8 bits wide so a large step past the bottom edge cannot wrap before the clamp test
    assign ny = {1'b0, asteroidy} + 8'd1 + {6'd0, level};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:     if (start) state_d = ST_SPAWN;
            ST_SPAWN:    state_d = ST_FALL;
            ST_FALL: begin
                if (destroy) begin
                    state_d = ST_COOLDOWN;
                end else if (tick_done && ny >= 8'(YMAX)) begin
                    state_d = ST_MISS;
                end
            end
            ST_COOLDOWN: if (cool_done) state_d = ST_SPAWN;
            ST_MISS:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_d      = asteroidx;
        y_d      = asteroidy;
        active_d = active;
        moved_d  = 1'b0;
        miss_d   = 1'b0;
        kill_d   = kill_cnt;
        level_d  = level;
        tick_d   = tick_cnt;
        cool_d   = cool_cnt;
        case (state)
            ST_IDLE: begin
                active_d = 1'b0;
                tick_d   = '0;
            end
            ST_SPAWN: begin
                x_d      = (lfsr <= 8'(XMAX)) ? lfsr : lfsr - 8'(XMAX + 1);
                y_d      = '0;
                active_d = 1'b1;
                moved_d  = 1'b1;
                tick_d   = '0;
            end
            ST_FALL: begin
                // destroy takes priority over a step landing on the same cycle
                if (destroy) begin
                    active_d = 1'b0;
                    kill_d   = kill_cnt + 3'd1;
                    if (kill_cnt == 3'd7 && level != 2'd3) level_d = level + 2'd1;
                    cool_d   = '0;
                    tick_d   = '0;
                end else if (tick_done) begin
                    tick_d  = '0;
                    moved_d = 1'b1;
                    y_d     = (ny >= 8'(YMAX)) ? Y_W'(YMAX) : ny[Y_W-1:0];
                end else begin
                    tick_d = tick_cnt + TW'(1);
                end
            end
            ST_COOLDOWN: begin
                if (tick_done) begin
                    tick_d = '0;
                    cool_d = cool_cnt + CW'(1);
                end else begin
                    tick_d = tick_cnt + TW'(1);
                end
            end
            ST_MISS: begin
                miss_d   = 1'b1;
                active_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            asteroidx <= '0;
            asteroidy <= '0;
            active    <= 1'b0;
            moved     <= 1'b0;
            miss      <= 1'b0;
            level     <= '0;
            kill_cnt  <= '0;
            tick_cnt  <= '0;
            cool_cnt  <= '0;
        end else begin
            asteroidx <= x_d;
            asteroidy <= y_d;
            active    <= active_d;
            moved     <= moved_d;
            miss      <= miss_d;
            level     <= level_d;
            kill_cnt  <= kill_d;
            tick_cnt  <= tick_d;
            cool_cnt  <= cool_d;
        end
    end

endmodule

// File: tb/tb_asteroid_controller.sv
// tb/tb_asteroid_controller.sv - directed self-checking bench for asteroid_controller
module tb_asteroid_controller;
    import asteroid_controller_pkg::*;

    localparam int         TD   = 4;
    localparam int         CT   = 2;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       destroy = 1'b0;
    logic [7:0] asteroidx;
    logic [6:0] asteroidy;
    logic       active, moved, miss;
    logic [1:0] level;
    logic [7:0] lfsr_m;
    int         n_asserts = 0;
    int         n_fails = 0;

    asteroid_controller #(
        .TICK_DIV       (TD),
        .COOLDOWN_TICKS (CT),
        .LFSR_SEED      (SEED)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .destroy   (destroy),
        .asteroidx (asteroidx),
        .asteroidy (asteroidy),
        .active    (active),
        .moved     (moved),
        .miss      (miss),
        .level     (level)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clock) lfsr_m <= reset ? SEED : lfsr_next(lfsr_m);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic spawn();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("spawn_state", dut.state, ST_SPAWN);
        tick();
        check("spawn_moved", moved, 1);
        check("spawn_y", asteroidy, 0);
        check("spawn_active", active, 1);
        check("spawn_x_range", asteroidx <= 8'd150, 1);
    endtask

    task automatic fall(input int inc, input int start_y, input int stop_y);
        int y_exp = start_y;
        while (y_exp < stop_y) begin
            y_exp = (y_exp + inc > 110) ? 110 : y_exp + inc;
            repeat (TD - 1) begin
                tick();
                check("fall_quiet_moved", moved, 0);
            end
            tick();
            check("fall_y", asteroidy, y_exp);
            check("fall_moved", moved, 1);
        end
    endtask

    task automatic check_miss(input int lvl);
        tick();
        check("miss_pulse", miss, 1);
        check("miss_active", active, 0);
        check("miss_y", asteroidy, 110);
        tick();
        check("miss_one_cycle", miss, 0);
        check("miss_to_idle", dut.state, ST_IDLE);
        check("miss_level_kept", level, lvl);
    endtask

    task automatic destroy_now();
        destroy = 1'b1;
        tick();
        destroy = 1'b0;
        check("destroy_active", active, 0);
        check("destroy_state", dut.state, ST_COOLDOWN);
    endtask

    task automatic wait_respawn(input int exp_edges);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!moved && n < 20);
        check("respawn_edges", n, exp_edges);
        check("respawn_y", asteroidy, 0);
        check("respawn_active", active, 1);
    endtask

    task automatic level_round(input int lvl_before);
        for (int i = 2; i <= 8; i++) begin
            destroy_now();
            check("level_after_destroy", level, (i == 8) ? lvl_before + 1 : lvl_before);
            wait_respawn(9);
        end
        check("kill_wrapped", dut.kill_cnt, 0);
    endtask

    initial begin
        int mv;
        bit found;

        repeat (3) tick();
        check("rst_x", asteroidx, 0);
        check("rst_y", asteroidy, 0);
        check("rst_active", active, 0);
        check("rst_moved", moved, 0);
        check("rst_miss", miss, 0);
        check("rst_level", level, 0);
        check("rst_state", dut.state, ST_IDLE);
        reset = 1'b0;
        mv = 0;
        repeat (50) begin
            tick();
            if (moved) mv++;
        end
        check("idle_no_moved", mv, 0);
        check("idle_active", active, 0);

        // raise start so the LFSR holds 200 on the SPAWN cycle
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (lfsr_next(lfsr_m) == 8'd200) found = 1'b1;
            else tick();
        end
        if (!found) begin
            $display("FAIL lfsr_search: value 200 not reached");
            $fatal(1);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wrap_state_spawn", dut.state, ST_SPAWN);
        tick();
        check("wrap_x", asteroidx, 49);
        check("wrap_y", asteroidy, 0);
        check("wrap_active", active, 1);
        check("wrap_moved", moved, 1);
        fall(1, 0, 110);
        check_miss(0);

        spawn();
        fall(1, 0, 20);
        destroy_now();
        check("destroy_y_hold", asteroidy, 20);
        check("destroy_kill", dut.kill_cnt, 1);
        wait_respawn(9);
        level_round(0);
        fall(2, 0, 110);
        check_miss(1);

        spawn();
        repeat (TD - 1) tick();
        destroy = 1'b1;
        tick();
        destroy = 1'b0;
        check("term_destroy_y", asteroidy, 0);
        check("term_destroy_moved", moved, 0);
        check("term_destroy_active", active, 0);
        check("term_destroy_state", dut.state, ST_COOLDOWN);
        check("term_destroy_kill", dut.kill_cnt, 1);
        destroy = 1'b1;
        tick();
        destroy = 1'b0;
        check("cool_destroy_kill", dut.kill_cnt, 1);
        check("cool_destroy_state", dut.state, ST_COOLDOWN);
        wait_respawn(8);
        level_round(1);
        fall(3, 0, 110);
        check_miss(2);

        destroy = 1'b1;
        tick();
        destroy = 1'b0;
        check("idle_destroy_kill", dut.kill_cnt, 0);
        check("idle_destroy_state", dut.state, ST_IDLE);

        spawn();
        repeat (5) tick();
        check("pre_reset_y", asteroidy, 3);
        reset = 1'b1;
        tick();
        check("midrst_x", asteroidx, 0);
        check("midrst_y", asteroidy, 0);
        check("midrst_active", active, 0);
        check("midrst_moved", moved, 0);
        check("midrst_miss", miss, 0);
        check("midrst_level", level, 0);
        check("midrst_state", dut.state, ST_IDLE);
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
